// File: rtl/beam_sum.sv
// Delay-and-sum beam combiner: captures one 16-channel frame, adds the enabled
// channels serially (one per clock), and presents sum/16 over valid/ready.
module beam_sum #(
    parameter int unsigned NUM_CH = 16,
    parameter int unsigned DATA_W = 19,
    parameter int unsigned ACC_W  = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] delayed_pcm_data_0,
    input  logic [DATA_W-1:0] delayed_pcm_data_1,
    input  logic [DATA_W-1:0] delayed_pcm_data_2,
    input  logic [DATA_W-1:0] delayed_pcm_data_3,
    input  logic [DATA_W-1:0] delayed_pcm_data_4,
    input  logic [DATA_W-1:0] delayed_pcm_data_5,
    input  logic [DATA_W-1:0] delayed_pcm_data_6,
    input  logic [DATA_W-1:0] delayed_pcm_data_7,
    input  logic [DATA_W-1:0] delayed_pcm_data_8,
    input  logic [DATA_W-1:0] delayed_pcm_data_9,
    input  logic [DATA_W-1:0] delayed_pcm_data_10,
    input  logic [DATA_W-1:0] delayed_pcm_data_11,
    input  logic [DATA_W-1:0] delayed_pcm_data_12,
    input  logic [DATA_W-1:0] delayed_pcm_data_13,
    input  logic [DATA_W-1:0] delayed_pcm_data_14,
    input  logic [DATA_W-1:0] delayed_pcm_data_15,
    input  logic [NUM_CH-1:0] channel_mask,
    input  logic              beam_ready,
    input  logic              clear_overrun,
    output logic [DATA_W-1:0] beam_data,
    output logic              beam_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned CNT_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] pcm    [NUM_CH];
    logic [DATA_W-1:0] snap_q [NUM_CH];
    logic [NUM_CH-1:0] mask_q;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] beam_data_d;
    logic              beam_valid_d, busy_d, overrun_d;
    logic              capture, drop;
    logic [DATA_W-1:0] cur;
    logic [ACC_W-1:0]  term, sum;

    assign pcm[0]  = delayed_pcm_data_0;
    assign pcm[1]  = delayed_pcm_data_1;
    assign pcm[2]  = delayed_pcm_data_2;
    assign pcm[3]  = delayed_pcm_data_3;
    assign pcm[4]  = delayed_pcm_data_4;
    assign pcm[5]  = delayed_pcm_data_5;
    assign pcm[6]  = delayed_pcm_data_6;
    assign pcm[7]  = delayed_pcm_data_7;
    assign pcm[8]  = delayed_pcm_data_8;
    assign pcm[9]  = delayed_pcm_data_9;
    assign pcm[10] = delayed_pcm_data_10;
    assign pcm[11] = delayed_pcm_data_11;
    assign pcm[12] = delayed_pcm_data_12;
    assign pcm[13] = delayed_pcm_data_13;
    assign pcm[14] = delayed_pcm_data_14;
    assign pcm[15] = delayed_pcm_data_15;

    // Current channel's contribution, sign-extended and masked
    always_comb begin
        cur  = snap_q[cnt_q];
        term = mask_q[cnt_q] ? {{(ACC_W-DATA_W){cur[DATA_W-1]}}, cur} : '0;
        sum  = acc_q + term;
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        beam_data_d  = beam_data;
        beam_valid_d = beam_valid;
        capture      = 1'b0;
        drop         = 1'b0;

        case (state_q)
            IDLE: begin
                capture = sample_valid;
            end
            ACCUM: begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
                drop  = sample_valid;
                if (cnt_q == CNT_W'(NUM_CH - 1)) begin
                    // Fixed divide by the channel count, floor via arithmetic shift
                    beam_data_d  = DATA_W'($signed(sum) >>> CNT_W);
                    beam_valid_d = 1'b1;
                    state_d      = OUTPUT;
                end
            end
            OUTPUT: begin
                if (beam_valid && beam_ready) begin
                    beam_valid_d = 1'b0;
                    state_d      = IDLE;
                    capture      = sample_valid;
                end else begin
                    drop = sample_valid;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ACCUM;
        end

        busy_d    = (state_d != IDLE);
        overrun_d = drop | (overrun & ~clear_overrun);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            beam_data  <= '0;
            beam_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            beam_data  <= beam_data_d;
            beam_valid <= beam_valid_d;
            busy       <= busy_d;
            overrun    <= overrun_d;
        end
    end

    // Frame snapshot; datapath only, so no reset needed
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < int'(NUM_CH); i++) snap_q[i] <= pcm[i];
            mask_q <= channel_mask;
        end
    end

endmodule

// File: tb/tb_beam_sum.sv
// Directed bench for beam_sum: a frame-level reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_beam_sum;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               sample_valid = 1'b0;
    logic signed [18:0] d [16];
    logic [15:0]        channel_mask = '0;
    logic               beam_ready = 1'b0;
    logic               clear_overrun = 1'b0;
    logic [18:0]        beam_data;
    logic               beam_valid, busy, overrun;

    int tests = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    beam_sum dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid),
        .delayed_pcm_data_0(d[0]),   .delayed_pcm_data_1(d[1]),
        .delayed_pcm_data_2(d[2]),   .delayed_pcm_data_3(d[3]),
        .delayed_pcm_data_4(d[4]),   .delayed_pcm_data_5(d[5]),
        .delayed_pcm_data_6(d[6]),   .delayed_pcm_data_7(d[7]),
        .delayed_pcm_data_8(d[8]),   .delayed_pcm_data_9(d[9]),
        .delayed_pcm_data_10(d[10]), .delayed_pcm_data_11(d[11]),
        .delayed_pcm_data_12(d[12]), .delayed_pcm_data_13(d[13]),
        .delayed_pcm_data_14(d[14]), .delayed_pcm_data_15(d[15]),
        .channel_mask(channel_mask), .beam_ready(beam_ready),
        .clear_overrun(clear_overrun), .beam_data(beam_data),
        .beam_valid(beam_valid), .busy(busy), .overrun(overrun)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Floor of (masked channel sum) / 16 using plain integer arithmetic
    function automatic int frame_avg();
        int s = 0;
        int q;
        for (int i = 0; i < 16; i++) if (channel_mask[i]) s += int'(d[i]);
        q = s / 16;
        if ((s % 16 != 0) && (s < 0)) q--;
        return q;
    endfunction

    // Reference model: a captured frame yields its result 16 clocks later
    int m_rem = 0, m_data = 0, m_pend = 0;
    bit m_valid = 0, m_ovr = 0, m_busy = 0, m_drop, m_start;

    always @(posedge clk) begin
        if (!rst) begin
            m_rem = 0; m_valid = 0; m_data = 0; m_ovr = 0; m_busy = 0;
        end else begin
            m_drop = 0; m_start = 0;
            if (m_rem > 0) begin
                m_drop = sample_valid;
                m_rem--;
                if (m_rem == 0) begin m_valid = 1; m_data = m_pend; end
            end else if (m_valid) begin
                if (beam_ready) begin m_valid = 0; m_start = sample_valid; end
                else m_drop = sample_valid;
            end else begin
                m_start = sample_valid;
            end
            if (m_start) begin m_pend = frame_avg(); m_rem = 16; end
            m_ovr  = m_drop | (m_ovr & !clear_overrun);
            m_busy = (m_rem > 0) || m_valid;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_beam_data", int'($signed(beam_data)), m_data);
            check("model_beam_valid", int'(beam_valid), int'(m_valid));
            check("model_busy", int'(busy), int'(m_busy));
            check("model_overrun", int'(overrun), int'(m_ovr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < 16; i++) d[i] = 19'(v);
    endtask

    task automatic send(input int v, input logic [15:0] m);
        set_all(v);
        channel_mask = m;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        set_all(12345);
        channel_mask = 16'h5A5A;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!beam_valid && n < 40) begin
            step();
            n++;
        end
        check(name, n, 16);
    endtask

    task automatic accept();
        beam_ready = 1'b1;
        step();
        beam_ready = 1'b0;
    endtask

    initial begin
        set_all(0);
        step();
        step();
        chk_en = 1'b1;
        check("rst_valid", int'(beam_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_data", int'(beam_data), 0);
        rst = 1'b1;
        step();

        // Basic average
        send(100, 16'hFFFF);
        check("t1_busy", int'(busy), 1);
        wait_valid("t1_latency");
        check("t1_data", int'($signed(beam_data)), 100);
        accept();
        check("t1_valid_after", int'(beam_valid), 0);
        check("t1_busy_after", int'(busy), 0);

        // Sign and floor: sum -8 -> -1
        for (int i = 0; i < 8; i++) d[i] = 19'(262143);
        for (int i = 8; i < 16; i++) d[i] = 19'(-262144);
        channel_mask = 16'hFFFF;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        set_all(0);
        wait_valid("t2_latency");
        check("t2_data", int'(beam_data), 32'h7FFFF);
        accept();

        // Masking
        send(160, 16'h000F);
        wait_valid("t3_latency");
        check("t3_data", int'($signed(beam_data)), 40);
        accept();
        send(160, 16'h0000);
        wait_valid("t3_zero_latency");
        check("t3_zero_valid", int'(beam_valid), 1);
        check("t3_zero_data", int'(beam_data), 0);
        accept();

        // Backpressure with dropped frames and overrun clear
        send(1000, 16'hFFFF);
        wait_valid("t4_latency");
        for (int k = 0; k < 10; k++) begin
            if (k == 3 || k == 7) begin set_all(7); sample_valid = 1'b1; end
            if (k == 5 || k == 7) clear_overrun = 1'b1;
            step();
            if (k == 5) check("t4_cleared_mid", int'(overrun), 0);
            if (k == 7) check("t4_set_wins", int'(overrun), 1);
            sample_valid = 1'b0;
            clear_overrun = 1'b0;
        end
        check("t4_data_held", int'($signed(beam_data)), 1000);
        check("t4_valid_held", int'(beam_valid), 1);
        check("t4_overrun", int'(overrun), 1);
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        check("t4_overrun_clr", int'(overrun), 0);
        accept();
        check("t4_valid_after", int'(beam_valid), 0);

        // Simultaneous accept and capture
        send(20, 16'hFFFF);
        wait_valid("t5_first_latency");
        check("t5_first_data", int'($signed(beam_data)), 20);
        set_all(50);
        channel_mask = 16'hFFFF;
        beam_ready = 1'b1;
        sample_valid = 1'b1;
        step();
        beam_ready = 1'b0;
        sample_valid = 1'b0;
        set_all(0);
        check("t5_overrun", int'(overrun), 0);
        check("t5_busy", int'(busy), 1);
        check("t5_valid_cleared", int'(beam_valid), 0);
        wait_valid("t5_latency");
        check("t5_data", int'($signed(beam_data)), 50);
        accept();

        // Reset mid-accumulation, then a fresh frame
        send(9, 16'hFFFF);
        for (int k = 0; k < 7; k++) step();
        rst = 1'b0;
        step();
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_valid", int'(beam_valid), 0);
        check("t6_rst_data", int'(beam_data), 0);
        check("t6_rst_overrun", int'(overrun), 0);
        rst = 1'b1;
        step();
        send(-32, 16'hFFFF);
        wait_valid("t6_latency");
        check("t6_data", int'($signed(beam_data)), -32);
        accept();
        step();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/beam_sum.md
# beam_sum

Delay-and-sum combiner on the read side of `delay_module`. It takes the 16 steered, 19-bit `delayed_pcm_data_*` channels and a per-sample strobe, then accumulates the enabled channels serially, one per clock. It outputs one 19-bit beamformed PCM sample per input frame over a valid/ready handshake, and sits between the delay stage and the downstream output/filter path.

## Interface
- `NUM_CH`, default 16: channel count; fixed at 16 (counter 4 bits, shift 4).
- `DATA_W`, default 19: PCM sample width, signed two's complement.
- `ACC_W`, default 23: accumulator width (DATA_W + 4).
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-low reset.
- `sample_valid`  in  1  one-cycle strobe: all 16 delayed samples are valid this cycle.
- `delayed_pcm_data_0` … `delayed_pcm_data_15`  in  19 each  steered channel samples, signed.
- `channel_mask`  in  16  bit i = 1 includes channel i; sampled with the frame.
- `beam_ready`  in  1  downstream accepts `beam_data`.
- `clear_overrun`  in  1  clears the sticky `overrun` flag.
- `beam_data`  out  19  beamformed sample, signed.
- `beam_valid`  out  1  `beam_data` valid; held until accepted.
- `busy`  out  1  high in ACCUM or OUTPUT.
- `overrun`  out  1  sticky: a frame was dropped.

## Operation
- The FSM has three states: IDLE, ACCUM, OUTPUT.
- **IDLE:** on `sample_valid` = 1, register all 16 samples into a snapshot array and `channel_mask` into a mask register. Then clear `acc` and `cnt` and go to ACCUM.
- **ACCUM:** each clock, `acc += mask[cnt] ? sext(snap[cnt]) : 0`, then increment `cnt`.
  - When `cnt` = 15, the final sum is `acc + term15`.
  - `beam_data` is loaded with that sum arithmetic-shifted right by 4 (floor division by 16, fixed divisor regardless of the mask).
  - `beam_valid` is set and the FSM goes to OUTPUT.
- **OUTPUT:** hold `beam_data` and `beam_valid`.
  - When `beam_valid` and `beam_ready` are both 1, clear `beam_valid`.
  - In that same cycle, if `sample_valid` = 1, capture the new frame and go directly to ACCUM; otherwise go to IDLE.
- **Dropped frames:** `sample_valid` in ACCUM, or in OUTPUT without a completing handshake, drops the frame and sets `overrun`. The state, snapshot, and accumulator are not affected.
- **Overrun clear:** `clear_overrun` clears `overrun`. If a drop happens in the same cycle, set wins.
- **Arithmetic:**
  - Samples are sign-extended to ACC_W. The maximum |sum| is 16·2^18 = 2^22, which fits in 23 bits signed, so overflow cannot occur.
  - The shifted result always fits in 19 bits; no saturation is needed.
- **Mask = 0:** the sum is 0 and `beam_data` = 0; the handshake proceeds normally.
- **Input stability:** `delayed_pcm_data_*` and `channel_mask` may change freely after the capture cycle; only the snapshot is used.

## Timing
- Reset (`rst` = 0 at a clock edge) forces the following on that edge, regardless of state: state = IDLE, `beam_data` = 0, `beam_valid` = 0, `busy` = 0, `overrun` = 0, `acc` = 0, `cnt` = 0. Any in-flight frame is discarded.
- Capture edge E0: `busy` = 1 after E0.
- Edges E1–E16: one channel is added per edge. After E16, `beam_valid` = 1 with the final `beam_data`, so latency is 16 clocks from the capture edge.
- Handshake completes on the first edge with `beam_valid` & `beam_ready`, which is E17 at the earliest. `busy` drops after that edge unless a new frame was captured.
- Minimum frame period with `beam_ready` tied high is 17 clocks. The audio frame rate is far below this.
- While `beam_valid` = 1 and `beam_ready` = 0, `beam_data` must not change.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- **Basic average:** all channels = 100, mask 0xFFFF, pulse `sample_valid` → 16 clocks later `beam_valid` = 1 and `beam_data` = 100. Accept with `beam_ready` = 1 → `beam_valid` = 0, `busy` = 0.
- **Sign/floor check:** ch0–7 = +262143, ch8–15 = −262144, mask 0xFFFF → sum = −8, `beam_data` = −1 (0x7FFFF).
- **Masking:** mask 0x000F, all channels = 160 → `beam_data` = 40. Mask 0x0000 → `beam_data` = 0 and `beam_valid` still asserts.
- **Backpressure and overrun:** hold `beam_ready` = 0 for 10 clocks after `beam_valid` and pulse a second `sample_valid` during that window (values 7) → `beam_data` holds its first value and `overrun` = 1. Pulse `clear_overrun` → `overrun` = 0.
- **Simultaneous accept and capture:** `beam_ready` = 1 and `sample_valid` = 1 (values 50) in the same cycle as the first `beam_valid` → `overrun` stays 0, `busy` stays 1, and the next `beam_data` = 50 after 16 clocks.
- **Reset mid-accumulation:** drive `rst` = 0 at `cnt` = 7 → all outputs are 0 on the next edge. After release, a fresh frame of all −32 gives `beam_data` = −32.
